csnc_rx_gather: RTL and testbench
=================================

# csnc_rx_gather

Erasure-side packet gatherer that sits directly upstream of the K=3, 12-bit CSNC erasure decoder. It accepts the coded packets of one generation as they survive the channel, each tagged with its role (0..2 systematic, 3..4 parity). It drops invalid, duplicate and parity-failing packets, and buffers the first K distinct good packets. It then presents them to the decoder as one K-beat burst with role sideband and tlast on the last beat.

## Interface
Parameters:
- W, 12, packet width (11 data bits + 1 even-parity MSB)
- K, 3, packets needed per generation
- N, 5, packets sent per generation (valid roles 0..N-1)
- ROLE_W, 3, role field width
- CNT_W, 16, statistics counter width

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  reset, asynchronous assert, active-high
- s_axis_tdata  in  W  received coded packet
- s_axis_role  in  ROLE_W  role of the packet
- s_axis_tvalid / s_axis_tready  in / out  1  input handshake
- s_axis_tlast  in  1  last packet the channel delivers for this generation
- m_axis_tdata  out  W  packet to decoder
- m_axis_role  out  ROLE_W  its role
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake
- m_axis_tlast  out  1  marks the K-th beat of a burst
- err_pulse  out  1  one-cycle pulse when a generation fails (tlast seen with fewer than K good packets)
- stat_gen_ok, stat_gen_fail, stat_drop  out  CNT_W each  saturating counters

## Operation
- Acceptance: an input beat is accepted when s_axis_tvalid && s_axis_tready.
- Good packet: an accepted packet is good when all three hold: role < N, seen_mask[role] == 0, and ^s_axis_tdata == 0 (even parity; XOR of lifted words preserves it).
- Good packet handling: write it to buffer slot cnt (arrival order), set seen_mask[role], increment cnt.
- Non-good packet: drop it and increment stat_drop, including packets dropped in FLUSH.
- FSM states: COLLECT, DRAIN, FLUSH.
- COLLECT: s_axis_tready = 1.
  - When the K-th good packet is accepted, go to DRAIN. Record tlast_seen = s_axis_tlast of that beat.
  - Accepted tlast with cnt < K after the beat: clear cnt and seen_mask, pulse err_pulse, increment stat_gen_fail, stay in COLLECT.
- DRAIN: s_axis_tready = 0. Emit slots 0..K-1 in order; m_axis_tlast = 1 on slot K-1.
  - On the final handshake, clear cnt and seen_mask and increment stat_gen_ok.
  - Then go to COLLECT if tlast_seen, else FLUSH.
- FLUSH: s_axis_tready = 1. Discard every beat. Leave for COLLECT on an accepted tlast.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset values: m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_role = 0, m_axis_tlast = 0, err_pulse = 0, all stat counters = 0. State = COLLECT, s_axis_tready = 1 from the first cycle after reset release.
- Latency: m_axis_tvalid rises the cycle after the K-th good accept.
- Back-to-back drain: with m_axis_tready held high, the K beats take K consecutive cycles.
- Output holding: all m_axis outputs are registered and held stable while m_axis_tvalid && !m_axis_tready.
- s_axis_tready depends only on state; it has no combinational path from m_axis_tready.
- Next generation: the first input of the next generation can be accepted the cycle after the last drain handshake, or after the FLUSH tlast.
- err_pulse is asserted in the cycle after the failing tlast accept.
- Reset mid-DRAIN or mid-FLUSH: asynchronously drop m_axis_tvalid, clear the buffer state, and return to COLLECT. The partial burst is not resumed.

## Structure
- Shared package csnc_pkg holds:
  - constants CSNC_K = 3, CSNC_N = 5, CSNC_W = 12, CSNC_ROLE_W = 3
  - role encoding: ROLE_D0..D2 = 0..2, ROLE_P0 = 3, ROLE_P1 = 4
  - gather_state_e enum {COLLECT, DRAIN, FLUSH}
- One sub-module: csnc_sat_cnt (parameterised saturating counter with inc input), instantiated three times.
- The buffer is an inline K-entry register array, with {tdata, role} per slot.

## Test plan
- Clean subset: roles 1, 3, 4 with data 0x003, 0x00F, 0x011, tlast on the third beat → output beats (0x003,1), (0x00F,3), (0x011,4,tlast); stat_gen_ok = 1; state returns to COLLECT.
- Full generation: roles 0..4 with all packets good, tlast on role 4 → roles 0, 1, 2 emitted; roles 3 and 4 consumed in FLUSH; stat_drop = 2.
- Duplicate and bad role: roles 2, 2, 7, 0, 4 → emits roles 2, 0, 4; stat_drop = 2.
- Parity erasure: role 1 with 0x001 (odd parity), then roles 0, 2, 3 good → role 1 dropped; emits 0, 2, 3.
- Underrun: roles 0, 3, with tlast on role 3 → no output, err_pulse for one cycle, stat_gen_fail = 1. The next generation decodes normally.
- Backpressure and reset: m_axis_tready toggled 1/0 during DRAIN → data held stable, 3 beats exact. Asserting areset on the second beat → m_axis_tvalid = 0 immediately, clean restart.

Source files
------------

// File: rtl/csnc_pkg.sv
// ----------------------------------------------------------------------------
// csnc_pkg
// Shared definitions for the K=3, 12-bit CSNC erasure path: code geometry,
// packet role encoding and the receive-gatherer state encoding.
// ----------------------------------------------------------------------------
package csnc_pkg;

  localparam int CSNC_K      = 3;   // packets needed to decode a generation
  localparam int CSNC_N      = 5;   // packets sent per generation
  localparam int CSNC_W      = 12;  // 11 data bits + even-parity MSB
  localparam int CSNC_ROLE_W = 3;

  // Roles 0..K-1 are systematic, the rest are parity combinations.
  typedef enum logic [CSNC_ROLE_W-1:0] {
    ROLE_D0 = 3'd0,
    ROLE_D1 = 3'd1,
    ROLE_D2 = 3'd2,
    ROLE_P0 = 3'd3,
    ROLE_P1 = 3'd4
  } csnc_role_e;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,  // gathering good packets
    DRAIN   = 2'd1,  // presenting the K buffered packets to the decoder
    FLUSH   = 2'd2   // discarding the surplus of a decoded generation
  } gather_state_e;

endpackage

// File: rtl/csnc_sat_cnt.sv
// ----------------------------------------------------------------------------
// csnc_sat_cnt
// Saturating event counter: increments by one on each cycle 'inc' is high and
// sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count this cycle
//   count : current value (registered)
// ----------------------------------------------------------------------------
module csnc_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csnc_rx_gather.sv
// ----------------------------------------------------------------------------
// csnc_rx_gather
// Erasure-side gatherer in front of the CSNC decoder. Accepts the surviving
// coded packets of a generation, drops invalid-role, duplicate-role and
// parity-failing packets, keeps the first K distinct good ones in arrival
// order and hands them to the decoder as one K-beat burst.
//
// Ports
//   aclk, areset            clock; asynchronous active-high reset
//   s_axis_tdata/role       received packet and its role (0..N-1 valid)
//   s_axis_tvalid/tready    input handshake (tready depends on state only)
//   s_axis_tlast            last packet the channel delivers this generation
//   m_axis_tdata/role       buffered packet towards the decoder, registered
//   m_axis_tvalid/tready    output handshake
//   m_axis_tlast            marks the K-th beat of a burst
//   err_pulse               one cycle after a tlast that left < K good packets
//   stat_gen_ok/fail/drop   saturating statistics counters
// ----------------------------------------------------------------------------
module csnc_rx_gather
  import csnc_pkg::*;
#(
  parameter int W      = CSNC_W,
  parameter int K      = CSNC_K,
  parameter int N      = CSNC_N,
  parameter int ROLE_W = CSNC_ROLE_W,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              areset,

  input  logic [W-1:0]      s_axis_tdata,
  input  logic [ROLE_W-1:0] s_axis_role,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,

  output logic [W-1:0]      m_axis_tdata,
  output logic [ROLE_W-1:0] m_axis_role,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,

  output logic              err_pulse,
  output logic [CNT_W-1:0]  stat_gen_ok,
  output logic [CNT_W-1:0]  stat_gen_fail,
  output logic [CNT_W-1:0]  stat_drop
);

  localparam int SLOT_W = (K > 1) ? $clog2(K) : 1;
  localparam int CNT_IW = $clog2(K + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  gather_state_e       state_q, state_d;
  logic [CNT_IW-1:0]   cnt_q, cnt_d;            // good packets held
  logic [N-1:0]        seen_q, seen_d;          // roles already held
  logic                tlast_seen_q, tlast_seen_d;
  logic [SLOT_W-1:0]   rd_idx_q, rd_idx_d;      // slot currently on m_axis

  logic [W-1:0]        buf_data_q [K];
  logic [W-1:0]        buf_data_d [K];
  logic [ROLE_W-1:0]   buf_role_q [K];
  logic [ROLE_W-1:0]   buf_role_d [K];

  logic                m_valid_q, m_valid_d;
  logic [W-1:0]        m_data_q,  m_data_d;
  logic [ROLE_W-1:0]   m_role_q,  m_role_d;
  logic                m_last_q,  m_last_d;
  logic                err_q,     err_d;

  // --------------------------------------------------------------------------
  // FSM output / decode logic
  // --------------------------------------------------------------------------
  logic                s_ready;
  logic                in_acc;
  logic [N-1:0]        role_bit;
  logic                in_good;
  logic                in_drop;
  logic                kth_good;
  logic                gen_fail;
  logic                out_hs;
  logic                last_hs;
  logic                flush_end;

  always_comb begin
    s_ready   = (state_q != DRAIN);
    in_acc    = s_axis_tvalid && s_ready;
    // Out-of-range roles shift the one-hot bit out entirely, giving zero.
    role_bit  = N'(1) << s_axis_role;
    in_good   = (state_q == COLLECT) && in_acc
                && (s_axis_role < ROLE_W'(N))
                && ((seen_q & role_bit) == '0)
                && !(^s_axis_tdata);
    in_drop   = in_acc && !in_good;
    kth_good  = in_good && (cnt_q == CNT_IW'(K - 1));
    // tlast that leaves fewer than K good packets ends the generation as lost.
    gen_fail  = (state_q == COLLECT) && in_acc && s_axis_tlast && !kth_good;
    out_hs    = (state_q == DRAIN) && m_valid_q && m_axis_tready;
    last_hs   = out_hs && (rd_idx_q == SLOT_W'(K - 1));
    flush_end = (state_q == FLUSH) && in_acc && s_axis_tlast;
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (kth_good)  state_d = DRAIN;
      DRAIN:   if (last_hs)   state_d = tlast_seen_q ? COLLECT : FLUSH;
      FLUSH:   if (flush_end) state_d = COLLECT;
      default:                state_d = COLLECT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Buffer, bookkeeping and output register next values
  // --------------------------------------------------------------------------
  logic [SLOT_W-1:0] wr_idx;
  logic [SLOT_W-1:0] rd_nxt;

  always_comb begin
    buf_data_d   = buf_data_q;
    buf_role_d   = buf_role_q;
    cnt_d        = cnt_q;
    seen_d       = seen_q;
    tlast_seen_d = tlast_seen_q;
    rd_idx_d     = rd_idx_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_role_d     = m_role_q;
    m_last_d     = m_last_q;
    err_d        = gen_fail;
    wr_idx       = SLOT_W'(cnt_q);
    rd_nxt       = rd_idx_q + SLOT_W'(1);

    if (in_good) begin
      buf_data_d[wr_idx] = s_axis_tdata;
      buf_role_d[wr_idx] = s_axis_role;
      cnt_d              = cnt_q + CNT_IW'(1);
      seen_d             = seen_q | role_bit;
    end

    if (gen_fail || last_hs) begin
      cnt_d  = '0;
      seen_d = '0;
    end

    if (kth_good) begin
      // Slot 0 is taken from the post-write view so K=1 also works.
      tlast_seen_d = s_axis_tlast;
      rd_idx_d     = '0;
      m_valid_d    = 1'b1;
      m_data_d     = buf_data_d[0];
      m_role_d     = buf_role_d[0];
      m_last_d     = (K == 1);
    end else if (out_hs) begin
      if (last_hs) begin
        m_valid_d = 1'b0;
        m_data_d  = '0;
        m_role_d  = '0;
        m_last_d  = 1'b0;
      end else begin
        rd_idx_d  = rd_nxt;
        m_data_d  = buf_data_q[rd_nxt];
        m_role_d  = buf_role_q[rd_nxt];
        m_last_d  = (rd_nxt == SLOT_W'(K - 1));
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      seen_q       <= '0;
      tlast_seen_q <= 1'b0;
      rd_idx_q     <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_role_q     <= '0;
      m_last_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      tlast_seen_q <= tlast_seen_d;
      rd_idx_q     <= rd_idx_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_role_q     <= m_role_d;
      m_last_q     <= m_last_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the packet buffer has no reset; a slot is only read after cnt_q
  // shows it was written this generation, and resetting cnt_q/seen_q is what
  // empties the buffer.
  always_ff @(posedge aclk) begin
    buf_data_q <= buf_data_d;
    buf_role_q <= buf_role_d;
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  csnc_sat_cnt #(.WIDTH(CNT_W)) u_cnt_ok (
    .clk   (aclk),
    .rst   (areset),
    .inc   (last_hs),
    .count (stat_gen_ok)
  );

  csnc_sat_cnt #(.WIDTH(CNT_W)) u_cnt_fail (
    .clk   (aclk),
    .rst   (areset),
    .inc   (gen_fail),
    .count (stat_gen_fail)
  );

  csnc_sat_cnt #(.WIDTH(CNT_W)) u_cnt_drop (
    .clk   (aclk),
    .rst   (areset),
    .inc   (in_drop),
    .count (stat_drop)
  );

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_role   = m_role_q;
  assign m_axis_tlast  = m_last_q;
  assign err_pulse     = err_q;

endmodule

// File: tb/tb_csnc_rx_gather.sv
// ----------------------------------------------------------------------------
// tb_csnc_rx_gather
// Directed scenarios for csnc_rx_gather. Inputs change 1 ns after the rising
// edge; outputs are observed on the falling edge.
// ----------------------------------------------------------------------------
module tb_csnc_rx_gather;
  import csnc_pkg::*;

  typedef struct packed {
    logic [11:0] d;
    logic [2:0]  r;
    logic        l;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [11:0] s_axis_tdata = '0;
  logic [2:0]  s_axis_role = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [11:0] m_axis_tdata;
  logic [2:0]  m_axis_role;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        err_pulse;
  logic [15:0] stat_gen_ok, stat_gen_fail, stat_drop;

  int tests_run = 0;
  int tests_failed = 0;

  csnc_rx_gather dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_role   (s_axis_role),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_role   (m_axis_role),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .err_pulse     (err_pulse),
    .stat_gen_ok   (stat_gen_ok),
    .stat_gen_fail (stat_gen_fail),
    .stat_drop     (stat_drop)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Output monitor: records every beat that will handshake on the next edge,
  // checks stall stability and counts err_pulse cycles.
  // --------------------------------------------------------------------------
  beat_t rx[$];
  beat_t held;
  logic  hold_pending = 1'b0;
  int    err_cnt = 0;

  always @(negedge aclk) begin
    if (areset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        tests_run++;
        if (!m_axis_tvalid || ({m_axis_tdata, m_axis_role, m_axis_tlast} !== held)) begin
          tests_failed++;
          $display("FAIL stall_hold got v=%b %h want v=1 %h", m_axis_tvalid,
                   {m_axis_tdata, m_axis_role, m_axis_tlast}, held);
        end
      end
      hold_pending = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tdata, m_axis_role, m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) rx.push_back(held);
      if (err_pulse) err_cnt++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  logic [11:0] tx_d [8];
  logic [2:0]  tx_r [8];
  logic        tx_l [8];
  int          tx_n;
  beat_t       exp_b [3];

  function automatic beat_t mk(input logic [11:0] d, input logic [2:0] r, input logic l);
    beat_t b;
    b.d = d; b.r = r; b.l = l;
    return b;
  endfunction

  task automatic set_tx(input int i, input logic [11:0] d, input logic [2:0] r, input logic l);
    tx_d[i] = d; tx_r[i] = r; tx_l[i] = l;
  endtask

  // Presents tx_* beats in order; each is held until the DUT accepts it.
  task automatic send_seq();
    int stall;
    @(posedge aclk); #1;
    for (int i = 0; i < tx_n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = tx_d[i];
      s_axis_role   = tx_r[i];
      s_axis_tlast  = tx_l[i];
      stall = 0;
      forever begin
        @(negedge aclk);
        if (s_axis_tready) begin
          @(posedge aclk); #1;
          break;
        end
        stall++;
        if (stall > 50) begin
          tests_run++;
          tests_failed++;
          $display("FAIL send_timeout beat %0d got tready=0 want 1", i);
          @(posedge aclk); #1;
          break;
        end
        @(posedge aclk); #1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Waits (bounded) for n captured beats, then a few more cycles for extras.
  task automatic wait_rx(input int n);
    int k = 0;
    while (rx.size() < n && k < 100) begin
      @(negedge aclk); #1;
      k++;
    end
    repeat (4) @(negedge aclk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge aclk);
    tests_run++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_role, m_axis_tlast, err_pulse} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got v=%b d=%h r=%0d l=%b e=%b want all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_role, m_axis_tlast, err_pulse);
    end
    tests_run++;
    if ({stat_gen_ok, stat_gen_fail, stat_drop} !== '0) begin
      tests_failed++;
      $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", stat_gen_ok, stat_gen_fail, stat_drop);
    end
    #1 areset = 1'b0;
    @(negedge aclk);
    tests_run++;
    if (s_axis_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_tready got %b want 1", s_axis_tready);
    end
  endtask

  task automatic test_clean_subset();
    beat_t got;
    int t_first;
    rx.delete();
    m_axis_tready = 1'b1;
    tx_n = 3;
    set_tx(0, 12'h003, 3'd1, 1'b0);
    set_tx(1, 12'h00F, 3'd3, 1'b0);
    set_tx(2, 12'h011, 3'd4, 1'b1);
    send_seq();
    // We are 1 ns past the K-th accept edge: tvalid must already be high.
    @(negedge aclk);
    tests_run++;
    if (m_axis_tvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL clean_latency got tvalid=%b want 1", m_axis_tvalid);
    end
    t_first = 0;
    // Back-to-back: three consecutive cycles of tvalid with tready high.
    for (int i = 1; i < 3; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid) t_first++;
    end
    tests_run++;
    if (t_first != 2) begin
      tests_failed++;
      $display("FAIL clean_back_to_back got %0d more valid cycles want 2", t_first);
    end
    wait_rx(3);
    exp_b[0] = mk(12'h003, 3'd1, 1'b0);
    exp_b[1] = mk(12'h00F, 3'd3, 1'b0);
    exp_b[2] = mk(12'h011, 3'd4, 1'b1);
    tests_run++;
    if (rx.size() != 3) begin
      tests_failed++;
      $display("FAIL clean_count got %0d beats want 3", rx.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx.size()) ? rx[i] : '0;
      tests_run++;
      if (got !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL clean_beat%0d got %h want %h", i, got, exp_b[i]);
      end
    end
    tests_run++;
    if (stat_gen_ok !== 16'd1 || stat_drop !== 16'd0 || s_axis_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL clean_stats got ok=%0d drop=%0d rdy=%b want 1 0 1", stat_gen_ok, stat_drop, s_axis_tready);
    end
  endtask

  task automatic test_full_generation();
    beat_t got;
    rx.delete();
    tx_n = 5;
    set_tx(0, 12'h003, 3'd0, 1'b0);
    set_tx(1, 12'h005, 3'd1, 1'b0);
    set_tx(2, 12'h006, 3'd2, 1'b0);
    set_tx(3, 12'h009, 3'd3, 1'b0);
    set_tx(4, 12'h00A, 3'd4, 1'b1);
    send_seq();
    wait_rx(3);
    exp_b[0] = mk(12'h003, 3'd0, 1'b0);
    exp_b[1] = mk(12'h005, 3'd1, 1'b0);
    exp_b[2] = mk(12'h006, 3'd2, 1'b1);
    tests_run++;
    if (rx.size() != 3) begin
      tests_failed++;
      $display("FAIL full_count got %0d beats want 3", rx.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx.size()) ? rx[i] : '0;
      tests_run++;
      if (got !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL full_beat%0d got %h want %h", i, got, exp_b[i]);
      end
    end
    tests_run++;
    if (stat_gen_ok !== 16'd2 || stat_drop !== 16'd2) begin
      tests_failed++;
      $display("FAIL full_stats got ok=%0d drop=%0d want 2 2", stat_gen_ok, stat_drop);
    end
  endtask

  task automatic test_duplicate_bad_role();
    beat_t got;
    rx.delete();
    tx_n = 5;
    set_tx(0, 12'h030, 3'd2, 1'b0);
    set_tx(1, 12'h0C0, 3'd2, 1'b0);
    set_tx(2, 12'h300, 3'd7, 1'b0);
    set_tx(3, 12'h0A0, 3'd0, 1'b0);
    set_tx(4, 12'h050, 3'd4, 1'b1);
    send_seq();
    wait_rx(3);
    exp_b[0] = mk(12'h030, 3'd2, 1'b0);
    exp_b[1] = mk(12'h0A0, 3'd0, 1'b0);
    exp_b[2] = mk(12'h050, 3'd4, 1'b1);
    tests_run++;
    if (rx.size() != 3) begin
      tests_failed++;
      $display("FAIL dup_count got %0d beats want 3", rx.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx.size()) ? rx[i] : '0;
      tests_run++;
      if (got !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL dup_beat%0d got %h want %h", i, got, exp_b[i]);
      end
    end
    tests_run++;
    if (stat_gen_ok !== 16'd3 || stat_drop !== 16'd4) begin
      tests_failed++;
      $display("FAIL dup_stats got ok=%0d drop=%0d want 3 4", stat_gen_ok, stat_drop);
    end
  endtask

  task automatic test_parity_erasure();
    beat_t got;
    rx.delete();
    tx_n = 4;
    set_tx(0, 12'h001, 3'd1, 1'b0);
    set_tx(1, 12'h011, 3'd0, 1'b0);
    set_tx(2, 12'h022, 3'd2, 1'b0);
    set_tx(3, 12'h044, 3'd3, 1'b1);
    send_seq();
    wait_rx(3);
    exp_b[0] = mk(12'h011, 3'd0, 1'b0);
    exp_b[1] = mk(12'h022, 3'd2, 1'b0);
    exp_b[2] = mk(12'h044, 3'd3, 1'b1);
    tests_run++;
    if (rx.size() != 3) begin
      tests_failed++;
      $display("FAIL parity_count got %0d beats want 3", rx.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx.size()) ? rx[i] : '0;
      tests_run++;
      if (got !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL parity_beat%0d got %h want %h", i, got, exp_b[i]);
      end
    end
    tests_run++;
    if (stat_gen_ok !== 16'd4 || stat_drop !== 16'd5) begin
      tests_failed++;
      $display("FAIL parity_stats got ok=%0d drop=%0d want 4 5", stat_gen_ok, stat_drop);
    end
  endtask

  task automatic test_underrun();
    beat_t got;
    rx.delete();
    err_cnt = 0;
    tx_n = 2;
    set_tx(0, 12'h003, 3'd0, 1'b0);
    set_tx(1, 12'h005, 3'd3, 1'b1);
    send_seq();
    @(negedge aclk);
    tests_run++;
    if (err_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL underrun_err_pulse got %b want 1", err_pulse);
    end
    @(negedge aclk);
    tests_run++;
    if (err_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL underrun_err_width got %b want 0", err_pulse);
    end
    repeat (4) @(negedge aclk);
    #1;
    tests_run++;
    if (rx.size() != 0 || err_cnt != 1 || stat_gen_fail !== 16'd1) begin
      tests_failed++;
      $display("FAIL underrun_result got beats=%0d errs=%0d fail=%0d want 0 1 1",
               rx.size(), err_cnt, stat_gen_fail);
    end
    // Next generation must start from an empty buffer and mask.
    tx_n = 3;
    set_tx(0, 12'h00C, 3'd4, 1'b0);
    set_tx(1, 12'h018, 3'd1, 1'b0);
    set_tx(2, 12'h030, 3'd0, 1'b1);
    send_seq();
    wait_rx(3);
    exp_b[0] = mk(12'h00C, 3'd4, 1'b0);
    exp_b[1] = mk(12'h018, 3'd1, 1'b0);
    exp_b[2] = mk(12'h030, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      got = (i < rx.size()) ? rx[i] : '0;
      tests_run++;
      if (got !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL underrun_next_beat%0d got %h want %h", i, got, exp_b[i]);
      end
    end
    tests_run++;
    if (stat_gen_ok !== 16'd5 || stat_drop !== 16'd5) begin
      tests_failed++;
      $display("FAIL underrun_next_stats got ok=%0d drop=%0d want 5 5", stat_gen_ok, stat_drop);
    end
  endtask

  task automatic test_backpressure();
    beat_t got;
    rx.delete();
    tx_n = 3;
    set_tx(0, 12'h101, 3'd0, 1'b0);
    set_tx(1, 12'h202, 3'd1, 1'b0);
    set_tx(2, 12'h404, 3'd2, 1'b1);
    m_axis_tready = 1'b0;
    fork
      send_seq();
      begin
        for (int k = 0; k < 60 && rx.size() < 3; k++) begin
          @(posedge aclk); #1;
          m_axis_tready = ~m_axis_tready;
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_rx(3);
    exp_b[0] = mk(12'h101, 3'd0, 1'b0);
    exp_b[1] = mk(12'h202, 3'd1, 1'b0);
    exp_b[2] = mk(12'h404, 3'd2, 1'b1);
    tests_run++;
    if (rx.size() != 3) begin
      tests_failed++;
      $display("FAIL bp_count got %0d beats want 3", rx.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx.size()) ? rx[i] : '0;
      tests_run++;
      if (got !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL bp_beat%0d got %h want %h", i, got, exp_b[i]);
      end
    end
    tests_run++;
    if (stat_gen_ok !== 16'd6) begin
      tests_failed++;
      $display("FAIL bp_stats got ok=%0d want 6", stat_gen_ok);
    end
  endtask

  task automatic test_reset_mid_drain();
    beat_t got;
    int k;
    rx.delete();
    m_axis_tready = 1'b1;
    tx_n = 3;
    set_tx(0, 12'h0FF, 3'd3, 1'b0);
    set_tx(1, 12'h00F, 3'd4, 1'b0);
    set_tx(2, 12'h0F0, 3'd2, 1'b1);
    send_seq();
    k = 0;
    while (rx.size() < 1 && k < 20) begin
      @(negedge aclk); #1;
      k++;
    end
    @(posedge aclk); #1;
    m_axis_tready = 1'b0;
    @(negedge aclk); #1;
    tests_run++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 12'h00F || m_axis_role !== 3'd4) begin
      tests_failed++;
      $display("FAIL rst_second_beat got v=%b d=%h r=%0d want 1 00f 4",
               m_axis_tvalid, m_axis_tdata, m_axis_role);
    end
    areset = 1'b1;
    #1;
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 12'h000) begin
      tests_failed++;
      $display("FAIL rst_async_drop got v=%b l=%b d=%h want 0 0 000",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    @(negedge aclk); #1;
    areset = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    tests_run++;
    if (s_axis_tready !== 1'b1 || {stat_gen_ok, stat_gen_fail, stat_drop} !== '0) begin
      tests_failed++;
      $display("FAIL rst_restart_state got rdy=%b stats=%0d/%0d/%0d want 1 0/0/0",
               s_axis_tready, stat_gen_ok, stat_gen_fail, stat_drop);
    end
    rx.delete();
    // Roles 3/4/2 were held before reset; a fresh mask must accept role 2 again.
    tx_n = 3;
    set_tx(0, 12'h003, 3'd2, 1'b0);
    set_tx(1, 12'h005, 3'd1, 1'b0);
    set_tx(2, 12'h006, 3'd0, 1'b1);
    send_seq();
    wait_rx(3);
    exp_b[0] = mk(12'h003, 3'd2, 1'b0);
    exp_b[1] = mk(12'h005, 3'd1, 1'b0);
    exp_b[2] = mk(12'h006, 3'd0, 1'b1);
    tests_run++;
    if (rx.size() != 3) begin
      tests_failed++;
      $display("FAIL rst_restart_count got %0d beats want 3", rx.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < rx.size()) ? rx[i] : '0;
      tests_run++;
      if (got !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL rst_restart_beat%0d got %h want %h", i, got, exp_b[i]);
      end
    end
    tests_run++;
    if (stat_gen_ok !== 16'd1 || stat_drop !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_restart_stats got ok=%0d drop=%0d want 1 0", stat_gen_ok, stat_drop);
    end
  endtask

  initial begin
    test_reset();
    test_clean_subset();
    test_full_generation();
    test_duplicate_bad_role();
    test_parity_erasure();
    test_underrun();
    test_backpressure();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
